// File: rtl/i2s_rx_controller.sv
// i2s_rx_controller: master-mode I2S receive front end.
// Generates BCLK/LRCLK from clk, deserialises each channel slot
// into a SAMPLE_W-bit sample and hands it downstream on a
// valid/ready handshake.
//
// Ports:
//   clk, rst       system clock, async active-high reset
//   enable         1 = run bit clocks and capture, 0 = idle
//   i2s_sd         serial data from codec (clk-synchronous)
//   i2s_bclk       bit clock to codec (registered)
//   i2s_lrclk      word select, 0 = left slot, 1 = right slot
//   sample_data    deserialised sample
//   sample_ch      channel of sample_data (0 = L, 1 = R)
//   sample_valid   sample_data/sample_ch valid
//   sample_ready   downstream accepts on valid && ready
//   overrun        sticky: a completed sample was dropped
//   overrun_clr    clears overrun (a coincident drop wins)
//
// Build option:
//   I2S_LEFT_JUST_EN  left-justified framing (no delay bit).
//                     Default is Philips I2S framing.

module i2s_rx_controller #(
    parameter int CLK_DIV  = 4,
    parameter int SAMPLE_W = 16,
    parameter int SLOT_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                i2s_sd,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_ch,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun,
    input  logic                overrun_clr
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(SLOT_W);

`ifdef I2S_LEFT_JUST_EN
    // Left-justified: MSB sits in the first bit of the slot.
    localparam int FIRST_BIT = 0;
`else
    // Philips: bit 0 of each slot is a one-bit delay.
    localparam int FIRST_BIT = 1;
`endif
    localparam int LAST_BIT = FIRST_BIT + SAMPLE_W - 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] SLOT_LAST = BIT_W'(SLOT_W - 1);
    localparam logic [BIT_W-1:0] FIRST_B   = BIT_W'(FIRST_BIT);
    localparam logic [BIT_W-1:0] LAST_B    = BIT_W'(LAST_BIT);
    localparam logic [BIT_W-1:0] SAMP_B    = BIT_W'(SAMPLE_W);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                state_q,        state_d;
    logic [DIV_W-1:0]      div_cnt_q,      div_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q,      bit_cnt_d;
    logic [SAMPLE_W-1:0]   shift_q,        shift_d;
    logic                  bclk_q,         bclk_d;
    logic                  lrclk_q,        lrclk_d;
    logic [SAMPLE_W-1:0]   sample_data_q,  sample_data_d;
    logic                  sample_ch_q,    sample_ch_d;
    logic                  sample_valid_q, sample_valid_d;
    logic                  overrun_q,      overrun_d;

    logic                  tick;
    logic                  rise;
    logic                  fall;
    logic                  complete;
    logic                  in_window;
    logic [BIT_W-1:0]      bit_offs;
    logic [SAMPLE_W-1:0]   shift_next;

    // Offset into the data window. Below FIRST_BIT this wraps to a
    // large value, so one unsigned compare covers both ends.
    assign bit_offs  = bit_cnt_q - FIRST_B;
    assign in_window = (bit_offs < SAMP_B);

    // Sample as it stands once the current serial bit is shifted in.
    assign shift_next = {shift_q[SAMPLE_W-2:0], i2s_sd};

    always_comb begin
        state_d        = state_q;
        div_cnt_d      = div_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        bclk_d         = bclk_q;
        lrclk_d        = lrclk_q;
        sample_data_d  = sample_data_q;
        sample_ch_d    = sample_ch_q;
        sample_valid_d = sample_valid_q;
        overrun_d      = overrun_q;
        tick           = 1'b0;
        rise           = 1'b0;
        fall           = 1'b0;
        complete       = 1'b0;

        unique case (state_q)
            IDLE: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                shift_d   = '0;
                bclk_d    = 1'b0;
                lrclk_d   = 1'b0;
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    // Abandon the frame; a pending sample is kept.
                    state_d   = IDLE;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    bclk_d    = 1'b0;
                    lrclk_d   = 1'b0;
                end else begin
                    tick = (div_cnt_q == DIV_LAST);
                    if (tick) begin
                        div_cnt_d = '0;
                        bclk_d    = ~bclk_q;
                        rise      = ~bclk_q;
                        fall      = bclk_q;
                    end else begin
                        div_cnt_d = div_cnt_q + 1'b1;
                    end

                    // Slot boundary flips word select on the same
                    // falling edge that restarts the bit count.
                    if (fall) begin
                        if (bit_cnt_q == SLOT_LAST) begin
                            bit_cnt_d = '0;
                            lrclk_d   = ~lrclk_q;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end

                    if (rise && in_window) begin
                        shift_d = shift_next;
                    end

                    complete = rise && (bit_cnt_q == LAST_B);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Output handshake. A completion in the accept cycle
        // replaces the outgoing sample without a bubble.
        if (complete && (!sample_valid_q || sample_ready)) begin
            sample_data_d  = shift_next;
            sample_ch_d    = lrclk_q;
            sample_valid_d = 1'b1;
        end else if (sample_valid_q && sample_ready) begin
            sample_valid_d = 1'b0;
        end

        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (complete && sample_valid_q && !sample_ready) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            div_cnt_q      <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            bclk_q         <= 1'b0;
            lrclk_q        <= 1'b0;
            sample_data_q  <= '0;
            sample_ch_q    <= 1'b0;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            div_cnt_q      <= div_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            bclk_q         <= bclk_d;
            lrclk_q        <= lrclk_d;
            sample_data_q  <= sample_data_d;
            sample_ch_q    <= sample_ch_d;
            sample_valid_q <= sample_valid_d;
            overrun_q      <= overrun_d;
        end
    end

    assign i2s_bclk     = bclk_q;
    assign i2s_lrclk    = lrclk_q;
    assign sample_data  = sample_data_q;
    assign sample_ch    = sample_ch_q;
    assign sample_valid = sample_valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_i2s_rx_controller.sv
// tb_i2s_rx_controller: scoreboard bench for i2s_rx_controller.
// A codec model follows BCLK/LRCLK and drives known words.

module tb_i2s_rx_controller;

    localparam int CLK_DIV  = 2;
    localparam int SAMPLE_W = 16;
    localparam int SLOT_W   = 32;
`ifdef I2S_LEFT_JUST_EN
    localparam int FIRST_BIT = 0;
`else
    localparam int FIRST_BIT = 1;
`endif
    localparam int LAST_BIT = FIRST_BIT + SAMPLE_W - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                enable;
    logic                i2s_sd;
    logic                i2s_bclk;
    logic                i2s_lrclk;
    logic [SAMPLE_W-1:0] sample_data;
    logic                sample_ch;
    logic                sample_valid;
    logic                sample_ready;
    logic                overrun;
    logic                overrun_clr;

    i2s_rx_controller #(
        .CLK_DIV  (CLK_DIV),
        .SAMPLE_W (SAMPLE_W),
        .SLOT_W   (SLOT_W)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .i2s_sd       (i2s_sd),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .sample_data  (sample_data),
        .sample_ch    (sample_ch),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [16:0] exp_q[$];
    logic [15:0] cd_l = 16'h0;
    logic [15:0] cd_r = 16'h0;
    int idx = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Codec: shifts on BCLK fall, restarts its bit index when
    // LRCLK changes, and is held at bit 0 while idle.
    initial begin : codec
        logic bclk_prev;
        logic lr_prev;
        logic [15:0] w;
        bclk_prev = 1'b0;
        lr_prev   = 1'b0;
        i2s_sd    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !enable) begin
                idx = 0;
            end else if (bclk_prev && !i2s_bclk) begin
                if (i2s_lrclk != lr_prev) idx = 0;
                else idx++;
            end
            bclk_prev = i2s_bclk;
            lr_prev   = i2s_lrclk;
            w = i2s_lrclk ? cd_r : cd_l;
            if (idx >= FIRST_BIT && idx <= LAST_BIT)
                i2s_sd = w[SAMPLE_W-1-(idx-FIRST_BIT)];
            else
                i2s_sd = 1'b0;
        end
    end

    // Monitor: every accepted transfer must match the next entry.
    initial begin : monitor
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && sample_valid === 1'b1 &&
                sample_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample: got %0h expected none",
                             {sample_ch, sample_data});
                end else begin
                    e = exp_q.pop_front();
                    check("sample", {15'd0, sample_ch, sample_data},
                          {15'd0, e});
                end
            end
        end
    end

    function automatic bit cond(int w);
        case (w)
            0: return sample_valid;
            1: return overrun;
            2: return i2s_lrclk && idx == LAST_BIT;
            3: return i2s_lrclk && idx == 8;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(string name, int w, int max);
        int n = 0;
        while (!cond(w) && n < max) begin
            step();
            n++;
        end
        check(name, {31'd0, cond(w)}, 32'd1);
    endtask

    task automatic wait_drain(string name, int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            step();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    function automatic bit sig(int w);
        return (w == 0) ? i2s_bclk : i2s_lrclk;
    endfunction

    // Cycles between two consecutive rising edges of a clock output.
    task automatic measure(int w, int max, output int cyc);
        int n = 0;
        while (sig(w) && n < max) begin step(); n++; end
        while (!sig(w) && n < max) begin step(); n++; end
        cyc = 0;
        while (sig(w) && cyc < max) begin step(); cyc++; end
        while (!sig(w) && cyc < max) begin step(); cyc++; end
    endtask

    initial begin : stim
        int cyc;
        int bad;
        rst          = 1'b0;
        enable       = 1'b0;
        sample_ready = 1'b0;
        overrun_clr  = 1'b0;
        #1;
        rst = 1'b1;
        #2;
        check("rst_bclk",  {31'd0, i2s_bclk}, 0);
        check("rst_lrclk", {31'd0, i2s_lrclk}, 0);
        check("rst_valid", {31'd0, sample_valid}, 0);
        check("rst_data",  {16'd0, sample_data}, 0);
        check("rst_ovr",   {31'd0, overrun}, 0);
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();

        // Continuous capture with ready held high.
        cd_l = 16'hA5C3;
        cd_r = 16'h1234;
        sample_ready = 1'b1;
        exp_q.push_back({1'b0, 16'hA5C3});
        exp_q.push_back({1'b1, 16'h1234});
        exp_q.push_back({1'b0, 16'hA5C3});
        exp_q.push_back({1'b1, 16'h1234});
        enable = 1'b1;
        measure(0, 50, cyc);
        check("bclk_period", cyc, 2 * CLK_DIV);
        measure(1, 700, cyc);
        check("lrclk_period", cyc, 4 * CLK_DIV * SLOT_W);
        wait_drain("drain_run", 800);
        enable = 1'b0;
        check("no_ovr_run", {31'd0, overrun}, 0);
        repeat (4) step();

        // Backpressure across two completions.
        sample_ready = 1'b0;
        enable = 1'b1;
        wait_for("ovr_valid", 0, 400);
        wait_for("ovr_set", 1, 400);
        check("ovr_hold_data", {16'd0, sample_data}, 32'hA5C3);
        check("ovr_hold_ch", {31'd0, sample_ch}, 0);
        enable = 1'b0;
        repeat (3) step();
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check("ovr_clr", {31'd0, overrun}, 0);
        check("ovr_pending", {31'd0, sample_valid}, 1);
        exp_q.push_back({1'b0, 16'hA5C3});
        sample_ready = 1'b1;
        step();
        check("ovr_valid_drop", {31'd0, sample_valid}, 0);
        wait_drain("drain_ovr", 10);
        repeat (4) step();

        // Disable in the middle of a right slot, then restart.
        exp_q.push_back({1'b0, 16'hA5C3});
        enable = 1'b1;
        wait_for("mid_right", 3, 600);
        enable = 1'b0;
        step();
        check("dis_bclk", {31'd0, i2s_bclk}, 0);
        check("dis_lrclk", {31'd0, i2s_lrclk}, 0);
        check("dis_queue", exp_q.size(), 0);
        bad = 0;
        repeat (20) begin
            step();
            if (sample_valid || i2s_bclk || i2s_lrclk) bad++;
        end
        check("dis_quiet", bad, 0);
        cd_l = 16'h8001;
        cd_r = 16'h7FFE;
        exp_q.push_back({1'b0, 16'h8001});
        exp_q.push_back({1'b1, 16'h7FFE});
        enable = 1'b1;
        wait_drain("drain_restart", 800);
        enable = 1'b0;
        repeat (4) step();

        // Accept in the same cycle a new sample completes.
        cd_l = 16'hA5C3;
        cd_r = 16'h1234;
        sample_ready = 1'b0;
        exp_q.push_back({1'b0, 16'hA5C3});
        exp_q.push_back({1'b1, 16'h1234});
        enable = 1'b1;
        wait_for("b2b_valid", 0, 400);
        wait_for("b2b_rlast", 2, 400);
        repeat (CLK_DIV - 1) step();
        sample_ready = 1'b1;
        step();
        sample_ready = 1'b0;
        check("b2b_valid_kept", {31'd0, sample_valid}, 1);
        check("b2b_data", {16'd0, sample_data}, 32'h1234);
        check("b2b_ch", {31'd0, sample_ch}, 1);
        check("b2b_no_ovr", {31'd0, overrun}, 0);
        enable = 1'b0;
        step();
        sample_ready = 1'b1;
        step();
        sample_ready = 1'b0;
        wait_drain("drain_b2b", 10);
        repeat (4) step();

        // Asynchronous reset while running with state pending.
        enable = 1'b1;
        wait_for("pre_rst_ovr", 1, 600);
        #3;
        rst = 1'b1;
        enable = 1'b0;
        #1;
        check("arst_bclk_lr", {30'd0, i2s_bclk, i2s_lrclk}, 0);
        check("arst_valid", {31'd0, sample_valid}, 0);
        check("arst_data", {15'd0, sample_ch, sample_data}, 0);
        check("arst_ovr", {31'd0, overrun}, 0);
        step();
        rst = 1'b0;
        bad = 0;
        repeat (20) begin
            step();
            if (i2s_bclk || i2s_lrclk || sample_valid) bad++;
        end
        check("post_rst_idle", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
